// File: rtl/sync_cnt_pkg.sv
// sync_cnt_pkg: direction constants and Gray conversion shared by the counter and its bench
package sync_cnt_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/bin2gray_n.sv
// bin2gray_n: combinational reflected-binary Gray encoder of parametrised width
module bin2gray_n
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = WIDTH'(bin2gray(32'(bin)));
endmodule

// File: rtl/sync_counter_n.sv
// sync_counter_n: modulus-N up/down counter with load, clear, wrap/saturate, Gray copy, cascade tc and sticky ovf
module sync_counter_n
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD = (WIDTH + 1)'(MODULUS);
  logic [WIDTH-1:0] nxt, nxt_gray;
  logic nxt_ovf, at_max, at_zero, up;
  assign up      = up_dn == CNT_UP;
  assign at_max  = count == MAX;
  assign at_zero = count == '0;
  assign tc      = en & (up ? at_max : at_zero);
  // tc marks exactly the edges that cross a limit, so it doubles as the overflow event
  always_comb begin
    nxt     = count;
    nxt_ovf = ovf;
    if (clear) begin
      nxt     = '0;
      nxt_ovf = 1'b0;
    end else if (load) begin
      nxt = ({1'b0, load_val} >= MOD) ? MAX : load_val;
    end else if (en) begin
      nxt_ovf = ovf | tc;
      nxt     = up ? (at_max ? (SATURATE ? MAX : '0) : count + WIDTH'(1))
                   : (at_zero ? (SATURATE ? '0 : MAX) : count - WIDTH'(1));
    end
  end
  bin2gray_n #(.WIDTH(WIDTH)) u_gray (.bin(nxt), .gray(nxt_gray));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      gray  <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= nxt;
      gray  <= nxt_gray;
      ovf   <= nxt_ovf;
    end
  end
endmodule

// File: tb/tb_sync_counter_n.sv
// tb_sync_counter_n: three counter flavours (mod 8, mod 6 wrap, mod 6 saturate) plus a two-stage cascade
module tb_sync_counter_n;
  import sync_cnt_pkg::*;
  logic clk = 1'b0;
  logic reset_n, clear, load, en, up_dn, en_c;
  logic [2:0] load_val;
  logic [2:0][2:0] cnt, gr;
  logic [2:0] tc, ov;
  logic [2:0] lo_cnt, lo_gr, hi_cnt, hi_gr;
  logic lo_tc, lo_ov, hi_tc, hi_ov;
  int n_tests = 0, n_fail = 0;
  int m_cnt[3], m_ovf[3];
  int mods[3] = '{8, 6, 6};
  int sats[3] = '{0, 0, 1};
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sync_counter_n #(.WIDTH(3), .MODULUS(g == 0 ? 8 : 6), .SATURATE(g == 2)) u_dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .count(cnt[g]), .gray(gr[g]), .tc(tc[g]), .ovf(ov[g]));
  end

  sync_counter_n #(.WIDTH(3)) u_lo (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .load(1'b0), .load_val(3'd0),
    .en(en_c), .up_dn(CNT_UP), .count(lo_cnt), .gray(lo_gr), .tc(lo_tc), .ovf(lo_ov));
  sync_counter_n #(.WIDTH(3)) u_hi (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .load(1'b0), .load_val(3'd0),
    .en(lo_tc), .up_dn(CNT_UP), .count(hi_cnt), .gray(hi_gr), .tc(hi_tc), .ovf(hi_ov));

  typedef struct {
    logic clr, ld, e, up;
    logic [2:0] lv;
    int c1, c2;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_tc(input int k);
    if (!en) return 0;
    return up_dn ? int'(m_cnt[k] == mods[k] - 1) : int'(m_cnt[k] == 0);
  endfunction

  // reference: step in signed arithmetic, then resolve anything outside 0..mod-1
  task automatic model_step(input int k);
    int raw;
    if (clear) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) < mods[k]) ? int'(load_val) : mods[k] - 1;
    end else if (en) begin
      raw = m_cnt[k] + (up_dn ? 1 : -1);
      if (raw < 0 || raw >= mods[k]) begin
        m_ovf[k] = 1;
        m_cnt[k] = sats[k] != 0 ? m_cnt[k] : (raw + mods[k]) % mods[k];
      end else m_cnt[k] = raw;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("count%0d", k), int'(cnt[k]), m_cnt[k]);
      chk($sformatf("gray%0d", k), int'(gr[k]), int'(bin2gray(32'(m_cnt[k]))));
      chk($sformatf("ovf%0d", k), int'(ov[k]), m_ovf[k]);
    end
  endtask

  task automatic cycle();
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("tc%0d", k), int'(tc[k]), model_tc(k));
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_state();
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [2:0] v);
    clear = c;
    load = l;
    en = e;
    up_dn = u;
    load_val = v;
  endtask

  initial begin
    int gray_tbl[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1, 1}, '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2, 2},
      '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3, 3}, '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4, 4},
      '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 5, 5}, '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 0, 5},
      '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1, 5}, '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2, 5},
      '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1, 4}, '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 0, 3},
      '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5, 2}, '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4, 1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3, 0}, '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2, 0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1, 0}, '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 3, 3}, '{1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 5, 5},
      '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5, 5}, '{1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 5, 5},
      '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 0, 0}, '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5, 0}
    };
    reset_n = 1'b0;
    en_c = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    model_reset();
    #10;
    check_state();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_tc%0d", k), int'(tc[k]), 0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("plain_count", int'(cnt[0]), (i + 1) % 8);
      chk("plain_gray", int'(gr[0]), gray_tbl[(i + 1) % 8]);
      chk("plain_ovf", int'(ov[0]), int'(i >= 7));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cycle();
    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].e, tbl[i].up, tbl[i].lv);
      cycle();
      chk($sformatf("vec%0d_mod6", i), int'(cnt[1]), tbl[i].c1);
      chk($sformatf("vec%0d_sat6", i), int'(cnt[2]), tbl[i].c2);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    cycle();
    chk("pre_reset_count", int'(cnt[0]), 4);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge clk);
    #1;
    chk("reset_hold_count", int'(cnt[0]), 0);
    chk("reset_hold_ovf", int'(ov[1]), 0);
    reset_n = 1'b1;
    cycle();
    chk("resume_count", int'(cnt[0]), 1);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
            1'($urandom_range(1)), 3'($urandom_range(7)));
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    cycle();
    chk("cascade_start", int'({hi_cnt, lo_cnt}), 0);
    en_c = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      chk("cascade_lo", int'(lo_cnt), (i + 1) % 8);
      chk("cascade_hi", int'(hi_cnt), ((i + 1) / 8) % 8);
    end
    chk("cascade_total", int'({hi_cnt, lo_cnt}), 70 % 64);
    en_c = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
